// File: rtl/cby_pkg.sv
// Shared types and elaboration-time helpers for the parametrised Y connection block.
package cby_pkg;

    typedef enum logic [1:0] {
        UNCFG   = 2'd0,
        LOADING = 2'd1,
        DONE    = 2'd2
    } cfg_state_t;

    localparam int DEF_CHAN_WIDTH = 20;
    localparam int DEF_NUM_IPIN   = 1;
    localparam int DEF_MUX_SIZE   = 10;
    localparam int DEF_TAP_STRIDE = 2;

    // Select width per mux; a 2-input mux still needs one bit.
    function automatic int sel_width(input int mux_size);
        return (mux_size < 2) ? 1 : $clog2(mux_size);
    endfunction

    // Track feeding input j of pin p; even/odd j share a track (bottom/top side).
    function automatic int tap_track(input int p, input int j, input int stride, input int width);
        return (p + (j >> 1) * stride) % width;
    endfunction

endpackage

// File: rtl/cby_ccff_chain.sv
// Configuration-chain segment: serial shift register, shifted-bit counter and load FSM.
//
// state   | meaning
// --------+-----------------------------------------------------------
// UNCFG   | after reset, nothing shifted yet, cfg_done low
// LOADING | shifting in progress, cnt = bits taken so far
// DONE    | cnt == CFG_BITS, segment programmed, cfg_done high
module cby_ccff_chain
    import cby_pkg::*;
#(
    parameter int CFG_BITS = 4
) (
    input  logic                prog_clk_i,
    input  logic                prog_reset_i,
    input  logic                ccff_head_i,
    input  logic                shift_en_i,
    output logic [CFG_BITS-1:0] cfg_o,
    output logic                ccff_tail_o,
    output logic                cfg_done_o
);

    localparam int               CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    cfg_state_t          state_q, state_d;

    always_ff @(posedge prog_clk_i) begin
        if (prog_reset_i) begin
            cfg_q   <= '0;
            cnt_q   <= '0;
            state_q <= UNCFG;
        end else begin
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Bit 0 takes the head; the top bit falls out as the tail.
    always_comb begin
        cfg_d = cfg_q;
        if (shift_en_i) begin
            cfg_d = CFG_BITS'({cfg_q, ccff_head_i});
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            UNCFG, DONE: begin
                // A shift out of DONE is a reconfiguration and restarts the count.
                if (shift_en_i) begin
                    cnt_d   = CNT_ONE;
                    state_d = (CNT_ONE == CNT_FULL) ? DONE : LOADING;
                end
            end
            LOADING: begin
                if (shift_en_i) begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = (cnt_d == CNT_FULL) ? DONE : LOADING;
                end
            end
            default: begin
                state_d = UNCFG;
                cnt_d   = '0;
            end
        endcase
    end

    assign cfg_o       = cfg_q;
    assign ccff_tail_o = cfg_q[CFG_BITS-1];
    assign cfg_done_o  = (state_q == DONE);

endmodule

// File: rtl/cby_param_ccff.sv
// Parametrised Y connection block: track pass-through, per-pin tap muxes gated by cfg_done.
// Optional CBY_IPIN_REG_EN registers the grid pins on prog_clk.
module cby_param_ccff
    import cby_pkg::*;
#(
    parameter int CHAN_WIDTH = DEF_CHAN_WIDTH,
    parameter int NUM_IPIN   = DEF_NUM_IPIN,
    parameter int MUX_SIZE   = DEF_MUX_SIZE,
    parameter int TAP_STRIDE = DEF_TAP_STRIDE
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic [CHAN_WIDTH-1:0] chany_bottom_in,
    input  logic [CHAN_WIDTH-1:0] chany_top_in,
    input  logic                  ccff_head,
    input  logic                  ccff_shift_en,
    output logic [CHAN_WIDTH-1:0] chany_bottom_out,
    output logic [CHAN_WIDTH-1:0] chany_top_out,
    output logic [NUM_IPIN-1:0]   left_grid_pin,
    output logic                  ccff_tail,
    output logic                  cfg_done
);

    localparam int SEL_W    = sel_width(MUX_SIZE);
    localparam int CFG_BITS = NUM_IPIN * SEL_W;

    if (MUX_SIZE < 2 || MUX_SIZE > 2 * CHAN_WIDTH) begin : g_bad_mux_size
        $error("cby_param_ccff: MUX_SIZE out of range 2..2*CHAN_WIDTH");
    end

    logic [CFG_BITS-1:0] cfg;
    logic [NUM_IPIN-1:0] mux_out;
    logic [NUM_IPIN-1:0] pin_gated;

    assign chany_top_out    = chany_bottom_in;
    assign chany_bottom_out = chany_top_in;

    cby_ccff_chain #(
        .CFG_BITS (CFG_BITS)
    ) u_chain (
        .prog_clk_i   (prog_clk),
        .prog_reset_i (prog_reset),
        .ccff_head_i  (ccff_head),
        .shift_en_i   (ccff_shift_en),
        .cfg_o        (cfg),
        .ccff_tail_o  (ccff_tail),
        .cfg_done_o   (cfg_done)
    );

    for (genvar p = 0; p < NUM_IPIN; p++) begin : g_pin
        logic [MUX_SIZE-1:0] taps;
        logic [SEL_W-1:0]    sel;
        logic                pin_mux;

        for (genvar j = 0; j < MUX_SIZE; j++) begin : g_tap
            localparam int TRK = tap_track(p, j, TAP_STRIDE, CHAN_WIDTH);
            if (j % 2 == 0) begin : g_even
                assign taps[j] = chany_bottom_in[TRK];
            end else begin : g_odd
                assign taps[j] = chany_top_in[TRK];
            end
        end

        assign sel = cfg[p*SEL_W +: SEL_W];

        // Unmatched selects (>= MUX_SIZE) fall through to 0.
        always_comb begin
            pin_mux = 1'b0;
            for (int j = 0; j < MUX_SIZE; j++) begin
                if (int'(sel) == j) begin
                    pin_mux = taps[j];
                end
            end
        end

        assign mux_out[p] = pin_mux;
    end

    assign pin_gated = cfg_done ? mux_out : '0;

`ifdef CBY_IPIN_REG_EN
    logic [NUM_IPIN-1:0] pin_q;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            pin_q <= '0;
        end else begin
            pin_q <= pin_gated;
        end
    end

    assign left_grid_pin = pin_q;
`else
    assign left_grid_pin = pin_gated;
`endif

endmodule

// File: tb/tb_cby_param_ccff.sv
// Directed self-checking bench for cby_param_ccff: a default tile and a 3-pin, 8-track tile.
module tb_cby_param_ccff;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic prog_reset;

    logic [19:0] a_bot_in, a_top_in, a_bot_out, a_top_out;
    logic        a_head, a_shift, a_tail, a_done;
    logic [0:0]  a_pin;

    logic [7:0]  b_bot_in, b_top_in, b_bot_out, b_top_out;
    logic        b_head, b_shift, b_tail, b_done;
    logic [2:0]  b_pin;

    int n_cmp = 0;
    int n_err = 0;

    cby_param_ccff u_dut_a (
        .prog_clk         (prog_clk),
        .prog_reset       (prog_reset),
        .chany_bottom_in  (a_bot_in),
        .chany_top_in     (a_top_in),
        .ccff_head        (a_head),
        .ccff_shift_en    (a_shift),
        .chany_bottom_out (a_bot_out),
        .chany_top_out    (a_top_out),
        .left_grid_pin    (a_pin),
        .ccff_tail        (a_tail),
        .cfg_done         (a_done)
    );

    cby_param_ccff #(
        .CHAN_WIDTH (8),
        .NUM_IPIN   (3),
        .MUX_SIZE   (4),
        .TAP_STRIDE (2)
    ) u_dut_b (
        .prog_clk         (prog_clk),
        .prog_reset       (prog_reset),
        .chany_bottom_in  (b_bot_in),
        .chany_top_in     (b_top_in),
        .ccff_head        (b_head),
        .ccff_shift_en    (b_shift),
        .chany_bottom_out (b_bot_out),
        .chany_top_out    (b_top_out),
        .left_grid_pin    (b_pin),
        .ccff_tail        (b_tail),
        .cfg_done         (b_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Let a track change reach the pin: a delta for the combinational build, one edge when registered.
    task automatic settle();
`ifdef CBY_IPIN_REG_EN
        @(negedge prog_clk);
`else
        #1;
`endif
    endtask

    // Shift four bits MSB first into tile A, recording the tail seen before each edge.
    task automatic load_a(input logic [3:0] v, output logic [3:0] tails);
        tails = 4'b0;
        for (int i = 3; i >= 0; i--) begin
            a_head  = v[i];
            a_shift = 1'b1;
            tails   = {tails[2:0], a_tail};
            if (i == 0) check_eq("a_pre_done", 32'(a_done), 32'd0);
            @(negedge prog_clk);
        end
        a_shift = 1'b0;
        a_head  = 1'b0;
    endtask

    task automatic load_b(input logic [5:0] v);
        for (int i = 5; i >= 0; i--) begin
            b_head  = v[i];
            b_shift = 1'b1;
            if (i == 0) check_eq("b_pre_done", 32'(b_done), 32'd0);
            @(negedge prog_clk);
        end
        b_shift = 1'b0;
        b_head  = 1'b0;
    endtask

    task automatic change_b(input string tag, input logic [7:0] bot, input logic [7:0] top,
                            input logic [2:0] old_pins, input logic [2:0] new_pins);
        b_bot_in = bot;
        b_top_in = top;
`ifdef CBY_IPIN_REG_EN
        #1;
        check_eq("b_pin_latency", 32'(b_pin), 32'(old_pins));
        @(negedge prog_clk);
`else
        #1;
`endif
        check_eq(tag, 32'(b_pin), 32'(new_pins));
    endtask

    initial begin
        logic [3:0] tails;

        prog_reset = 1'b1;
        a_bot_in = '0; a_top_in = '0; a_head = 1'b0; a_shift = 1'b0;
        b_bot_in = '0; b_top_in = '0; b_head = 1'b0; b_shift = 1'b0;
        repeat (2) @(negedge prog_clk);
        prog_reset = 1'b0;

        // Reset state and pass-through
        check_eq("a_rst_done", 32'(a_done), 32'd0);
        check_eq("a_rst_tail", 32'(a_tail), 32'd0);
        check_eq("a_rst_pin",  32'(a_pin),  32'd0);
        check_eq("b_rst_done", 32'(b_done), 32'd0);
        a_bot_in = 20'hABCDE;
        a_top_in = 20'h12345;
        #1;
        check_eq("a_top_out", 32'(a_top_out), 32'h000ABCDE);
        check_eq("a_bot_out", 32'(a_bot_out), 32'h00012345);
        a_bot_in = '1;
        a_top_in = '1;
        settle();
        check_eq("a_unconf_pin", 32'(a_pin), 32'd0);

        // sel=3: pin follows chany_top_in[2]
        load_a(4'b0011, tails);
        check_eq("a_tail_0011", 32'(tails), 32'h0);
        check_eq("a_done_0011", 32'(a_done), 32'd1);
        a_top_in = '0;
        settle();
        check_eq("a_sel3_lo", 32'(a_pin), 32'd0);
        a_top_in[2] = 1'b1;
        settle();
        check_eq("a_sel3_hi", 32'(a_pin), 32'd1);

        // sel=10 is the first out-of-range select
        load_a(4'b1010, tails);
        check_eq("a_tail_1010", 32'(tails), 32'h3);
        check_eq("a_done_1010", 32'(a_done), 32'd1);
        a_top_in = '1;
        a_bot_in = '1;
        settle();
        check_eq("a_sel10_zero", 32'(a_pin), 32'd0);

        // sel=9 is the last valid input: top track 8
        load_a(4'b1001, tails);
        check_eq("a_tail_1001", 32'(tails), 32'hA);
        a_bot_in = '0;
        a_top_in = '1;
        settle();
        check_eq("a_sel9_hi", 32'(a_pin), 32'd1);
        a_top_in[8] = 1'b0;
        settle();
        check_eq("a_sel9_lo", 32'(a_pin), 32'd0);
        a_top_in[8] = 1'b1;
        settle();
        check_eq("a_sel9_hi2", 32'(a_pin), 32'd1);

        // Reconfiguration from DONE: 0,0,1 then an idle cycle then 1 -> cfg 0011
        a_head = 1'b0; a_shift = 1'b1;
        @(negedge prog_clk);
        a_shift = 1'b0;
        check_eq("a_reconf_drop", 32'(a_done), 32'd0);
        settle();
        check_eq("a_reconf_pin0", 32'(a_pin), 32'd0);
        a_head = 1'b0; a_shift = 1'b1;
        @(negedge prog_clk);
        a_head = 1'b1;
        @(negedge prog_clk);
        a_shift = 1'b0;
        @(negedge prog_clk);
        check_eq("a_reconf_hold", 32'(a_done), 32'd0);
        a_head = 1'b1; a_shift = 1'b1;
        @(negedge prog_clk);
        a_shift = 1'b0; a_head = 1'b0;
        check_eq("a_reconf_done", 32'(a_done), 32'd1);
        settle();
        check_eq("a_reconf_pin1", 32'(a_pin), 32'd1);

        // Reset mid-load wins over shift_en
        a_head = 1'b1; a_shift = 1'b1;
        repeat (2) @(negedge prog_clk);
        prog_reset = 1'b1;
        @(negedge prog_clk);
        prog_reset = 1'b0;
        a_shift = 1'b0; a_head = 1'b0;
        check_eq("a_midrst_done", 32'(a_done), 32'd0);
        check_eq("a_midrst_tail", 32'(a_tail), 32'd0);
        check_eq("a_midrst_pin",  32'(a_pin),  32'd0);
        load_a(4'b0011, tails);
        check_eq("a_midrst_cfg0", 32'(tails), 32'h0);
        check_eq("a_reload_done", 32'(a_done), 32'd1);
        settle();
        check_eq("a_reload_pin", 32'(a_pin), 32'd1);

        // Tile B: pin0 sel1 (top 0), pin1 sel2 (bottom 3), pin2 sel3 (top 4)
        b_bot_in = '1;
        b_top_in = '1;
        settle();
        check_eq("b_unconf_pin", 32'(b_pin), 32'd0);
        load_b(6'b11_10_01);
        check_eq("b_done", 32'(b_done), 32'd1);
        b_bot_in = '0;
        b_top_in = '0;
        settle();
        settle();
        check_eq("b_pins_zero", 32'(b_pin), 32'd0);
        change_b("b_pin0_top0",   8'h00, 8'h01, 3'b000, 3'b001);
        change_b("b_pin1_bot3",   8'h08, 8'h01, 3'b001, 3'b011);
        change_b("b_pin2_top4",   8'h08, 8'h11, 3'b011, 3'b111);
        change_b("b_unmapped",    8'hF7, 8'hEE, 3'b111, 3'b000);
        change_b("b_pin1_only",   8'h08, 8'h00, 3'b000, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cby_param_ccff.md
Name: cby_param_ccff

Overview:
- Parametrised Y-direction connection block. Generalises the fixed single-pin, 20-track CBY to N tracks and M input pins, each driven by a K-input tree mux.
- Owns its configuration-chain segment: shift register, bit counter and load-state FSM. A cfg_done flag gates the grid pins to 0 until the segment is fully programmed.
- Sits between the switch blocks above and below, in the configuration daisy-chain between neighbouring tiles.

Parameters:
- CHAN_WIDTH, 20, tracks per direction.
- NUM_IPIN, 1, grid input pins driven.
- MUX_SIZE, 10, inputs per ipin mux (2..2*CHAN_WIDTH).
- TAP_STRIDE, 2, track spacing between mux taps.
- SEL_W, $clog2(MUX_SIZE), select bits per mux (derived).
- CFG_BITS, NUM_IPIN*SEL_W, chain length (derived).

Ports:
- prog_clk  in  1  sole clock; config and optional pin register.
- prog_reset  in  1  synchronous, active-high reset.
- chany_bottom_in  in  CHAN_WIDTH  tracks entering from below.
- chany_top_in  in  CHAN_WIDTH  tracks entering from above.
- ccff_head  in  1  serial config data in.
- ccff_shift_en  in  1  shift qualifier; one bit consumed per cycle while high.
- chany_bottom_out  out  CHAN_WIDTH  equals chany_top_in.
- chany_top_out  out  CHAN_WIDTH  equals chany_bottom_in.
- left_grid_pin  out  NUM_IPIN  mux outputs to the grid.
- ccff_tail  out  1  serial config data out.
- cfg_done  out  1  segment fully loaded.

Behaviour:
- One clock, prog_clk. Reset is synchronous and active-high, on prog_reset; sampled only at the rising edge of prog_clk.
- Pass-through:
  - chany_top_out[i]=chany_bottom_in[i] and chany_bottom_out[i]=chany_top_in[i].
  - Purely combinational; unaffected by reset.
- Config register cfg[0:CFG_BITS-1]:
  - When ccff_shift_en=1: cfg[0]<=ccff_head and cfg[i]<=cfg[i-1].
  - ccff_tail = cfg[CFG_BITS-1] (registered, one cycle per stage).
  - When ccff_shift_en=0 all cfg bits hold.
- Select field: sel[p] = cfg[p*SEL_W +: SEL_W]; the MSB is the first bit shifted in for that field.
- Tap map:
  - Mux input j of ipin p uses track t=(p+(j>>1)*TAP_STRIDE) mod CHAN_WIDTH.
  - Source is chany_bottom_in[t] for even j and chany_top_in[t] for odd j.
  - With defaults, pin 0 taps tracks 0,2,4,6,8.
- Mux output is in[sel[p]]. A select value >= MUX_SIZE yields 0.
- Counter cnt, width $clog2(CFG_BITS+1), counts shifted bits.
- FSM:
  - UNCFG: the reset state; cnt=0, cfg_done=0.
  - LOADING: entered on the first shift; cnt increments per shift.
    - The shift that makes cnt==CFG_BITS moves to DONE; cfg_done=1 on the next cycle.
    - shift_en low holds state and cnt.
  - DONE: cnt saturates at CFG_BITS.
    - Any shift re-enters LOADING with cnt=1 and drops cfg_done the following cycle (reconfiguration).
- Gating: left_grid_pin[p] = cfg_done ? mux_out : 0.
- Reset values:
  - cfg all 0, cnt 0, state UNCFG.
  - cfg_done=0, ccff_tail=0, left_grid_pin=0.
- Reset mid-load: reset wins over shift_en; all of the above return to reset values in the same edge.
- Latency:
  - Config bit head-to-tail: CFG_BITS cycles of shift_en.
  - Track-to-pin: combinational, unless the optional feature is enabled.

Optional Feature:
- Macro: CBY_IPIN_REG_EN.
- Defined:
  - left_grid_pin is registered on prog_clk, adding 1 cycle of latency.
  - Reset value 0.
  - The gating by cfg_done is applied before the register.
- Undefined: left_grid_pin is combinational from the tracks; no pin flops.

Decomposition:
- Shared package cby_pkg:
  - cfg_state_t enum {UNCFG, LOADING, DONE}.
  - Function tap_track(p,j,stride,width).
  - Localparam helper for SEL_W.
- One natural sub-module: cby_ccff_chain. It holds the shift register, counter and FSM, and exposes cfg bus, ccff_tail and cfg_done.
- Mux array and pass-through stay in the top.

Test Plan:
- Reset, then default params (CFG_BITS=4): all outputs 0, cfg_done=0. chany_bottom_in=20'hABCDE -> chany_top_out=20'hABCDE.
- Shift 4'b0011 (MSB first) over 4 cycles -> cfg_done=1 on cycle 5; sel=3 so pin0 follows chany_top_in[2]. Toggle chany_top_in[2] 0->1 -> left_grid_pin=1 same cycle.
- Load sel=4'b1100 (12>=10) -> left_grid_pin=0 for any track values; ccff_tail emits previous bits 0,0,1,1 during the shift.
- In DONE, assert shift_en for 1 cycle -> cfg_done falls next cycle and pin forced 0. Complete 3 more shifts -> cfg_done returns.
- Assert prog_reset after 2 of 4 shifts -> cnt=0, cfg=0, ccff_tail=0. The next full 4-bit load completes normally.
- NUM_IPIN=3, CHAN_WIDTH=8, MUX_SIZE=4, with CBY_IPIN_REG_EN: load sel={1,2,3} -> each pin reflects the mapped track one cycle after the track change; pin2 with j=3 maps to top track (2+2)%8=4.
